// File: rtl/tri_st_cntz64_seq.sv
// tri_st_cntz64_seq: iterative 64/32-bit leading/trailing zero counter, 16 bits per cycle
module tri_st_cntz64_seq #(
  parameter bit EARLY_OUT = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        word,
  input  logic        trailing,
  input  logic [0:63] data_i,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [0:6]  count,
  output logic [0:5]  amt,
  output logic        right,
  output logic        zero
);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t state, nxt;
  logic [0:63] d;
  logic [0:15] c_q, chunk;
  logic        wd, tr, ph, found, nz, last, fin;
  logic [1:0]  idx, fi, pos;
  logic [4:0]  z;
  logic [6:0]  acc, val;
  function automatic logic [4:0] lz16(input logic [0:15] c);
    lz16 = 5'd16;
    for (int i = 15; i >= 0; i--) if (c[i]) lz16 = 5'(i);
  endfunction
  function automatic logic [4:0] tz16(input logic [0:15] c);
    tz16 = 5'd16;
    for (int i = 0; i < 16; i++) if (c[i]) tz16 = 5'(15 - i);
  endfunction
  // The chunk is prefetched into c_q one cycle ahead of its evaluation, so the
  // operand mux stays off the count path; ph marks the priming cycle.
  always_comb begin
    fi    = ph ? idx + 2'd1 : 2'd0;
    pos   = tr ? ~fi : (wd ? {1'b1, fi[0]} : fi);
    chunk = d[{pos, 4'b0000} +: 16];
    z     = tr ? tz16(c_q) : lz16(c_q);
    nz    = |c_q;
    last  = idx == (wd ? 2'd1 : 2'd3);
    fin   = ph & (last | (EARLY_OUT & nz));
    val   = {1'b0, idx, 4'b0000} + {2'b00, z};
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = (in_valid & ~flush) ? SCAN : IDLE;
      SCAN:    nxt = flush ? IDLE : (fin ? DONE : SCAN);
      DONE:    nxt = (flush | out_ready) ? IDLE : DONE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d     <= '0;
      wd    <= 1'b0;
      tr    <= 1'b0;
      ph    <= 1'b0;
      found <= 1'b0;
      idx   <= '0;
      acc   <= '0;
      c_q   <= '0;
      count <= '0;
      right <= 1'b0;
      zero  <= 1'b0;
    end else begin
      if (state == IDLE && in_valid && !flush) begin
        d     <= data_i;
        wd    <= word;
        tr    <= trailing;
        ph    <= 1'b0;
        found <= 1'b0;
        idx   <= '0;
        acc   <= '0;
      end
      if (state == SCAN && !flush) begin
        c_q <= chunk;
        ph  <= 1'b1;
        if (ph) begin
          idx <= idx + 2'd1;
          if (nz && !found) begin
            found <= 1'b1;
            acc   <= val;
          end
        end
        if (fin) begin
          count <= found ? acc : val;
          right <= tr;
          zero  <= ~found & ~nz;
        end
      end
    end
  end
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign amt       = count[1:6];
endmodule

// File: doc/tri_st_cntz64_seq.md
Name: tri_st_cntz64_seq

Overview:
- Iterative 64-bit leading/trailing zero counter in the fixed-point (st) unit. It is the inverse companion of the 64-bit rotator.
- Given an operand, it computes the rotate amount that normalizes it:
  - leading mode: rotate left by the count to bring the first one to bit 0;
  - trailing mode: rotate right by the count to bring the last one to bit 63.
- Scans 16 bits per cycle with a valid/ready handshake on both sides. Supports doubleword and word (bits 32:63) operation.

Parameters:
- EARLY_OUT, 1, 1 = finish at the first nonzero chunk; 0 = always scan every chunk for the mode (fixed latency).

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  abort current operation.
- in_valid  in  1  operand offered.
- in_ready  out  1  block can accept an operand.
- word  in  1  1 = count over data_i[32:63] only.
- trailing  in  1  0 = leading zeros (from bit 0 / bit 32); 1 = trailing zeros (from bit 63).
- data_i  in  [0:63]  operand; bit 0 is the MSB.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- count  out  [0:6]  zero count: 0..64 for doubleword, 0..32 for word.
- amt  out  [0:5]  count[1:6], the rotate amount (mod 64).
- right  out  1  registered copy of trailing; rotate direction for amt.
- zero  out  1  operand (or its word) is all zeros.

Behaviour:
- States: IDLE, SCAN, DONE.
- in_ready = (state==IDLE).
- Reset (async) forces IDLE. Output values during and after reset: in_ready=1, out_valid=0, count=0, amt=0, right=0, zero=0. The internal chunk index and the operand/word/trailing registers are all cleared.
- IDLE:
  - When in_valid & in_ready & ~flush, capture data_i, word, trailing; clear the chunk index and accumulator; go to SCAN.
  - flush in the same cycle blocks acceptance.
- SCAN (one chunk per cycle):
  - Doubleword leading order: 0:15, 16:31, 32:47, 48:63.
  - Doubleword trailing order: 48:63, 32:47, 16:31, 0:15.
  - Word leading order: 32:47, 48:63. Word trailing order: 48:63, 32:47.
  - Each cycle: if the chunk is nonzero (and EARLY_OUT=1), or it is the last chunk for the mode, register count = 16*(chunks already passed) + lz16/tz16 of the chunk, and go to DONE.
  - Otherwise increment the chunk index and stay in SCAN.
  - With EARLY_OUT=0, the first nonzero chunk's value is latched and later chunks are ignored.
- Result values:
  - All-zero operand: count = 64 (doubleword) or 32 (word), zero=1.
  - Word amt = count[1:6], so amt=32 for an all-zero word and amt=0 for an all-zero doubleword.
- Latency: out_valid rises N+1 clocks after the accepting edge, where N = chunks scanned (doubleword 1..4, word 1..2). With EARLY_OUT=0, N = 4 or 2.
- DONE:
  - out_valid=1. count, amt, right, zero are held stable while out_ready=0.
  - out_valid & out_ready: go to IDLE. out_valid drops the next cycle; in_ready rises the same edge. There is no back-to-back acceptance from DONE.
- flush:
  - In SCAN or DONE, flush forces IDLE on the next edge and drops out_valid.
  - Any result that was not taken is discarded. Result outputs hold their last values.
  - flush takes priority over out_ready.
- Bits 0:31 are ignored in word mode regardless of value.
- count/amt/right/zero are only meaningful while out_valid=1.

Test Plan:
- Doubleword leading, data_i=0x0000_0000_0001_0000, out_ready=1 -> 3 chunks; out_valid 4 clocks after accept; count=47, amt=47, right=0, zero=0; in_ready back high the cycle after the handshake.
- Doubleword leading, data_i=0 -> out_valid 5 clocks after accept; count=64, amt=0, zero=1. Repeat with data_i=0x8000_0000_0000_0000 -> count=0, latency 2.
- Word trailing, data_i=0xFFFF_FFFF_0000_0100 -> count=8, amt=8, right=1, zero=0, latency 2 (upper bits ignored). Same with data_i=0xFFFF_FFFF_0000_0000 -> count=32, amt=32, zero=1, latency 3.
- Backpressure: hold out_ready=0 for 3 cycles in DONE while driving in_valid=1 with a new operand -> outputs stable, in_ready=0, second operand not accepted until 1 cycle after the handshake.
- Abort: assert flush during the 2nd SCAN cycle, then assert rst asynchronously mid-SCAN on a separate run -> out_valid never asserts; in_ready=1 after flush edge / immediately on rst; a following operand completes correctly.
- EARLY_OUT=0: data_i=0x0001_0000_0000_0000 leading -> count=15, out_valid exactly 5 clocks after accept.
